// File: rtl/si_cmd_writer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | si_cmd_writer_pkg : FSM encoding and byte-count sizing        |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package si_cmd_writer_pkg;

  typedef enum logic [1:0] {
    RX_ADDR = 2'd0,
    RX_DATA = 2'd1,
    ISSUE   = 2'd2
  } si_state_t;

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int byte_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/si_cmd_writer_byte_asm.sv
`default_nettype none
// +--------------------------------------------------------------+
// | si_byte_assembler : MSB-first byte shift register + counter   |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module si_byte_assembler
  import si_cmd_writer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] value,
  output logic             last,
  output logic             active
);

  localparam int c_NBYTES = WIDTH / 8;
  localparam int c_CW     = byte_cnt_width(c_NBYTES);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NBYTES - 1);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_value;

  assign last   = (r_count == c_LAST);
  assign active = (r_count != '0);
  assign value  = r_value;

  // Counter wraps to zero on the final byte so the field restarts cleanly.
  always_ff @(posedge clk) begin
    if (rst)
      r_count <= '0;
    else if (shift_en)
      r_count <= last ? '0 : r_count + c_ONE;
  end

  if (c_NBYTES == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (rst)
        r_value <= '0;
      else if (shift_en)
        r_value <= byte_in;
    end
  end else begin : g_multi
    always_ff @(posedge clk) begin
      if (rst)
        r_value <= '0;
      else if (shift_en)
        r_value <= {r_value[WIDTH-9:0], byte_in};
    end
  end

endmodule
`default_nettype wire

// File: rtl/si_cmd_writer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | si_cmd_writer : byte-stream command frames to register writes |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module si_cmd_writer
  import si_cmd_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_ack,
  output logic [ADDR_WIDTH-1:0] si_addr,
  output logic [DATA_WIDTH-1:0] si_data,
  output logic                  si_rdy,
  input  logic                  si_ack,
  output logic                  wr_done,
  output logic                  wr_err,
  output logic                  busy
);

  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  si_state_t  r_state;
  si_state_t  w_next;
  logic       w_rx_ack;
  logic       w_addr_shift;
  logic       w_data_shift;
  logic       w_addr_last;
  logic       w_data_last;
  logic       w_addr_active;
  logic       w_data_active;
  logic       w_done;
  logic       w_err;
  logic       r_si_rdy;
  logic       r_wr_done;
  logic       r_wr_err;
  logic [7:0] r_tmo;

  si_byte_assembler #(.WIDTH(ADDR_WIDTH)) u_addr_asm (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_addr_shift),
    .byte_in  (rx_data),
    .value    (si_addr),
    .last     (w_addr_last),
    .active   (w_addr_active)
  );

  si_byte_assembler #(.WIDTH(DATA_WIDTH)) u_data_asm (
    .clk      (clk),
    .rst      (rst),
    .shift_en (w_data_shift),
    .byte_in  (rx_data),
    .value    (si_data),
    .last     (w_data_last),
    .active   (w_data_active)
  );

  always_comb begin
    w_next       = r_state;
    w_rx_ack     = 1'b0;
    w_addr_shift = 1'b0;
    w_data_shift = 1'b0;
    w_done       = 1'b0;
    w_err        = 1'b0;
    if (!rst) begin
      case (r_state)
        RX_ADDR: begin
          w_rx_ack     = rx_rdy;
          w_addr_shift = rx_rdy;
          if (rx_rdy && w_addr_last) w_next = RX_DATA;
        end
        RX_DATA: begin
          w_rx_ack     = rx_rdy;
          w_data_shift = rx_rdy;
          if (rx_rdy && w_data_last) w_next = ISSUE;
        end
        ISSUE: begin
          // An ack landing on the final timeout cycle still wins.
          if (r_si_rdy && si_ack) begin
            w_done = 1'b1;
            w_next = RX_ADDR;
          end else if (r_tmo == c_TMO_LAST) begin
            w_err  = 1'b1;
            w_next = RX_ADDR;
          end
        end
        default: w_next = RX_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RX_ADDR;
      r_si_rdy  <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
      r_tmo     <= 8'd0;
    end else begin
      r_state   <= w_next;
      r_si_rdy  <= (w_next == ISSUE);
      r_wr_done <= w_done;
      r_wr_err  <= w_err;
      r_tmo     <= (r_state == ISSUE && w_next == ISSUE) ? r_tmo + 8'd1 : 8'd0;
    end
  end

  assign rx_ack  = w_rx_ack;
  assign si_rdy  = r_si_rdy;
  assign wr_done = r_wr_done;
  assign wr_err  = r_wr_err;
  assign busy    = !rst && (w_addr_active || w_data_active || r_state != RX_ADDR);

endmodule
`default_nettype wire

// File: tb/tb_si_cmd_writer.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_si_cmd_writer : scoreboard bench for three configurations  |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tb_si_cmd_writer;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic [2:0] rx_rdy;
  logic [2:0] rx_ack;

  logic [15:0] si_addr0, si_data0, si_addr1, si_data1;
  logic [7:0]  si_addr2;
  logic [31:0] si_data2;
  logic [2:0]  si_rdy, si_ack, wr_done, wr_err, busy;
  logic [2:0][31:0] m_addr, m_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] reg_1234, reg_000a;
  logic [31:0] reg2_0a;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  si_cmd_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(15)) u_dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy[0]), .rx_ack(rx_ack[0]),
    .si_addr(si_addr0), .si_data(si_data0), .si_rdy(si_rdy[0]), .si_ack(si_ack[0]),
    .wr_done(wr_done[0]), .wr_err(wr_err[0]), .busy(busy[0]));

  si_cmd_writer #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy[1]), .rx_ack(rx_ack[1]),
    .si_addr(si_addr1), .si_data(si_data1), .si_rdy(si_rdy[1]), .si_ack(si_ack[1]),
    .wr_done(wr_done[1]), .wr_err(wr_err[1]), .busy(busy[1]));

  si_cmd_writer #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(15)) u_dut2 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy[2]), .rx_ack(rx_ack[2]),
    .si_addr(si_addr2), .si_data(si_data2), .si_rdy(si_rdy[2]), .si_ack(si_ack[2]),
    .wr_done(wr_done[2]), .wr_err(wr_err[2]), .busy(busy[2]));

  assign m_addr[0] = {16'h0, si_addr0};
  assign m_addr[1] = {16'h0, si_addr1};
  assign m_addr[2] = {24'h0, si_addr2};
  assign m_data[0] = {16'h0, si_data0};
  assign m_data[1] = {16'h0, si_data1};
  assign m_data[2] = si_data2;

  // Register bank models: dut0 maps 0x1234 and 0x000A, dut1 acks everything, dut2 maps 0x0A.
  assign si_ack[0] = si_rdy[0] && (si_addr0 == 16'h1234 || si_addr0 == 16'h000A);
  assign si_ack[1] = si_rdy[1];
  assign si_ack[2] = si_rdy[2] && (si_addr2 == 8'h0A);

  always @(posedge clk) begin
    if (si_ack[0]) begin
      if (si_addr0 == 16'h1234) reg_1234 <= si_data0;
      else reg_000a <= si_data0;
    end
    if (si_ack[2]) reg2_0a <= si_data2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  int          rdy_cnt [3];
  logic [31:0] cap_a   [3];
  logic [31:0] cap_d   [3];

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        rdy_cnt[d] = 0;
      end else begin
        if (si_rdy[d]) begin
          rdy_cnt[d]++;
          cap_a[d] = m_addr[d];
          cap_d[d] = m_data[d];
          if (rx_rdy[d]) chk($sformatf("dut%0d_rx_ack_in_issue", d), {31'h0, rx_ack[d]}, 32'h0);
        end
        if (wr_done[d] || wr_err[d]) begin
          chk($sformatf("dut%0d_done_and_err", d), {31'h0, wr_done[d] & wr_err[d]}, 32'h0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_pulse: got done=%0b err=%0b, required no pulse",
                     d, wr_done[d], wr_err[d]);
          end else begin
            e = sb.pop_front();
            chk($sformatf("dut%0d_owner", d), d, e.dut);
            chk($sformatf("dut%0d_si_addr", d), cap_a[d], e.addr);
            chk($sformatf("dut%0d_si_data", d), cap_d[d], e.data);
            chk($sformatf("dut%0d_wr_err", d), {31'h0, wr_err[d]}, {31'h0, e.err});
            chk($sformatf("dut%0d_si_rdy_cycles", d), rdy_cnt[d], e.cyc);
          end
          rdy_cnt[d] = 0;
        end
      end
    end
  end

  task automatic send_byte(input int d, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    rx_data   = b;
    rx_rdy[d] = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      #1;
      if (rx_ack[d]) ok = 1'b1;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_send_%h: rx_ack stayed 0 for 64 cycles, required 1", d, b);
    end
  endtask

  task automatic send_frame(input int d, input int n, input logic [39:0] bytes);
    for (int i = 0; i < n; i++) send_byte(d, bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic push(input int d, input logic [31:0] a, input logic [31:0] v,
                      input logic err, input int cyc);
    exp_t e;
    e.dut = d; e.addr = a; e.data = v; e.err = err; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    rx_rdy[d] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) begin
      @(negedge clk);
      #1;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    rx_rdy  = 3'b111;
    rx_data = 8'hA5;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_dut%0d_si_rdy", d), {31'h0, si_rdy[d]}, 32'h0);
      chk($sformatf("rst_dut%0d_si_addr", d), m_addr[d], 32'h0);
      chk($sformatf("rst_dut%0d_si_data", d), m_data[d], 32'h0);
      chk($sformatf("rst_dut%0d_pulses", d), {30'h0, wr_done[d], wr_err[d]}, 32'h0);
      chk($sformatf("rst_dut%0d_busy", d), {31'h0, busy[d]}, 32'h0);
      chk($sformatf("rst_dut%0d_rx_ack", d), {31'h0, rx_ack[d]}, 32'h0);
    end
    @(negedge clk);
    rst    = 1'b0;
    rx_rdy = 3'b000;

    // Mapped write.
    push(0, 32'h1234, 32'hABCD, 1'b0, 1);
    send_frame(0, 4, 40'h00_1234_ABCD);
    idle(0);
    drain();
    chk("reg_1234_after_write", {16'h0, reg_1234}, 32'hABCD);

    // Unmapped write times out after exactly 15 request cycles.
    push(0, 32'h0099, 32'h5555, 1'b1, 15);
    send_frame(0, 4, 40'h00_0099_5555);
    idle(0);
    drain();
    chk("busy_after_timeout", {31'h0, busy[0]}, 32'h0);

    // Two frames with rx_rdy held high throughout.
    push(0, 32'h1234, 32'h1122, 1'b0, 1);
    push(0, 32'h000A, 32'h3344, 1'b0, 1);
    send_frame(0, 4, 40'h00_1234_1122);
    send_frame(0, 4, 40'h00_000A_3344);
    idle(0);
    drain();
    chk("reg_1234_b2b", {16'h0, reg_1234}, 32'h1122);
    chk("reg_000a_b2b", {16'h0, reg_000a}, 32'h3344);

    // Reset mid-frame discards the partial frame.
    send_frame(0, 3, 40'h00_0012_34AB);
    idle(0);
    repeat (2) @(negedge clk);
    #1;
    chk("busy_mid_frame", {31'h0, busy[0]}, 32'h1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("busy_in_reset", {31'h0, busy[0]}, 32'h0);
    rst = 1'b0;
    push(0, 32'h000A, 32'h0007, 1'b0, 1);
    send_frame(0, 4, 40'h00_000A_0007);
    idle(0);
    drain();
    chk("reg_000a_after_reset", {16'h0, reg_000a}, 32'h0007);

    // TIMEOUT=1 with ack on the first request cycle.
    push(1, 32'h5566, 32'h7788, 1'b0, 1);
    send_frame(1, 4, 40'h00_5566_7788);
    idle(1);
    drain();

    // 8-bit address, 32-bit data.
    push(2, 32'h0000_000A, 32'hDEAD_BEEF, 1'b0, 1);
    send_frame(2, 5, 40'h0A_DEAD_BEEF);
    idle(2);
    drain();
    chk("reg2_0a", reg2_0a, 32'hDEAD_BEEF);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
